// File: rtl/puf_pkg.sv
// Shared PUF definitions used by the SHA block sequencer.
//   sha_seq_state_t : sequencer FSM states
//   SHA_BLOCK_W     : width of one SHA-256 message block
//   SHA_PAD_BYTE    : first padding byte following the message
//   SHA_MSG_LEN     : message length field (bits) for a 256-bit message
package puf_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_WAIT_RDY,
        SEQ_INIT,
        SEQ_WAIT_ACK,
        SEQ_WAIT_DIG
    } sha_seq_state_t;

    localparam int          SHA_BLOCK_W  = 512;
    localparam logic [7:0]  SHA_PAD_BYTE = 8'h80;
    localparam logic [63:0] SHA_MSG_LEN  = 64'd256;

endpackage

// File: rtl/sha_block_sequencer_if.sv
// Handshake bundle between the block sequencer and the SHA-256 core.
//   sha_init         : one-cycle init pulse to the core
//   sha_next         : next-block request (unused, tied low)
//   sha_mode         : 1 selects SHA-256
//   sha_block        : padded 512-bit message block
//   sha_ready        : core idle
//   sha_digest_valid : core digest valid
//   sha_digest       : core digest
// master = sequencer side, slave = hash core side.
interface sha_block_sequencer_if;
    import puf_pkg::*;

    logic                   sha_init;
    logic                   sha_next;
    logic                   sha_mode;
    logic [SHA_BLOCK_W-1:0] sha_block;
    logic                   sha_ready;
    logic                   sha_digest_valid;
    logic [255:0]           sha_digest;

    modport master (
        output sha_init, sha_next, sha_mode, sha_block,
        input  sha_ready, sha_digest_valid, sha_digest
    );

    modport slave (
        input  sha_init, sha_next, sha_mode, sha_block,
        output sha_ready, sha_digest_valid, sha_digest
    );

endinterface

// File: rtl/sha_block_sequencer.sv
// Sequences one SHA-256 hash of the corrected PUF response.
// On start, latches data_in into a single padded 512-bit block, issues one
// init to the hash core, waits for the core to accept it and then for the
// fresh digest, and presents that digest with a one-cycle valid pulse.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : one-cycle pulse, data_in valid
//   data_in      : 256-bit corrected response
//   sha          : hash core handshake (master side)
//   digest       : last captured digest
//   digest_valid : one-cycle pulse when digest updates
//   busy         : high whenever not idle
//   overrun      : sticky, start seen while busy
//   timeout_err  : one-cycle pulse when a run is aborted
module sha_block_sequencer
    import puf_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [255:0]           data_in,
    sha_block_sequencer_if.master  sha,
    output logic [255:0]           digest,
    output logic                   digest_valid,
    output logic                   busy,
    output logic                   overrun,
    output logic                   timeout_err
);

    // Counter value at which the final permitted wait cycle is reached.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    sha_seq_state_t   state;
    logic [CNT_W-1:0] cnt;

    assign sha.sha_next = 1'b0;
    assign sha.sha_mode = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SEQ_IDLE;
            cnt           <= '0;
            sha.sha_init  <= 1'b0;
            sha.sha_block <= '0;
            digest        <= '0;
            digest_valid  <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            sha.sha_init <= 1'b0;
            digest_valid <= 1'b0;
            timeout_err  <= 1'b0;

            // busy mirrors state != IDLE, so this also flags a start that
            // lands on the edge where WAIT_DIG completes.
            if (start && busy)
                overrun <= 1'b1;

            case (state)
                SEQ_IDLE: begin
                    if (start) begin
                        sha.sha_block <= {data_in, SHA_PAD_BYTE, 184'h0, SHA_MSG_LEN};
                        busy          <= 1'b1;
                        state         <= SEQ_WAIT_RDY;
                    end
                end
                SEQ_WAIT_RDY: begin
                    if (sha.sha_ready) begin
                        sha.sha_init <= 1'b1;
                        state        <= SEQ_INIT;
                    end
                end
                SEQ_INIT: begin
                    cnt   <= '0;
                    state <= SEQ_WAIT_ACK;
                end
                SEQ_WAIT_ACK: begin
                    // Waiting for ready to drop keeps a stale digest_valid
                    // from the previous run from being captured.
                    if (cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= SEQ_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (!sha.sha_ready)
                            state <= SEQ_WAIT_DIG;
                    end
                end
                SEQ_WAIT_DIG: begin
                    if (sha.sha_digest_valid) begin
                        digest       <= sha.sha_digest;
                        digest_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= SEQ_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= SEQ_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= SEQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_block_sequencer.sv
// Directed self-checking bench for sha_block_sequencer with a behavioural
// hash core: it accepts init one cycle late, drops ready and digest_valid,
// and after core_lat cycles raises both again with core_value. digest_valid
// then stays high (stale) until the next init is accepted.
module tb_sha_block_sequencer;

    localparam logic [255:0] STALE  = 256'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [255:0] DIG_Z  = 256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925;
    localparam logic [255:0] DIG_A  = 256'h12345678_9abcdef0_12345678_9abcdef0_12345678_9abcdef0_12345678_9abcdef0;
    localparam logic [255:0] DIG_B  = 256'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_01234567_89abcdef_fedcba98_76543210;
    localparam logic [255:0] DAT_A  = 256'ha5a5a5a5_5a5a5a5a_00000000_ffffffff_11111111_22222222_33333333_44444444;
    localparam logic [255:0] DAT_B  = 256'hc0ffee00_00000001_80000000_00000000_deadbeef_cafebabe_01010101_fefefefe;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [255:0] data_in = '0;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;
    logic         overrun;
    logic         timeout_err;

    int checks = 0;
    int failures = 0;

    // Core model controls: cmd 0 = run, 1 = idle/flush, 2 = preload stale digest.
    int           core_cmd = 0;
    int           core_lat = 10;
    bit           core_never = 1'b0;
    logic [255:0] core_value = '0;

    logic         m_ready = 1'b1;
    logic         m_dv = 1'b0;
    logic [255:0] m_dig = '0;
    logic         m_pend = 1'b0;
    logic         m_run = 1'b0;
    int           m_cnt = 0;

    int init_cnt = 0;
    int dv_cnt = 0;
    bit saw_stale = 1'b0;

    sha_block_sequencer_if bus ();

    assign bus.sha_ready        = m_ready;
    assign bus.sha_digest_valid = m_dv;
    assign bus.sha_digest       = m_dig;

    sha_block_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .data_in      (data_in),
        .sha          (bus.master),
        .digest       (digest),
        .digest_valid (digest_valid),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_cmd == 1) begin
            m_ready <= 1'b1; m_dv <= 1'b0; m_pend <= 1'b0; m_run <= 1'b0;
        end else if (core_cmd == 2) begin
            m_ready <= 1'b1; m_dv <= 1'b1; m_dig <= STALE; m_pend <= 1'b0; m_run <= 1'b0;
        end else begin
            if (bus.sha_init)
                m_pend <= 1'b1;
            if (m_pend) begin
                m_pend  <= 1'b0;
                m_ready <= 1'b0;
                m_dv    <= 1'b0;
                m_run   <= 1'b1;
                m_cnt   <= core_lat;
            end else if (m_run && !core_never) begin
                if (m_cnt == 1) begin
                    m_dv    <= 1'b1;
                    m_dig   <= core_value;
                    m_ready <= 1'b1;
                    m_run   <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.sha_init)
            init_cnt++;
        if (digest_valid)
            dv_cnt++;
        if (digest === STALE)
            saw_stale = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        core_cmd = 1;
        tick();
        reset = 1'b0;
        core_cmd = 0;
    endtask

    // Drives start for one edge; data_in is scrambled afterwards so a
    // late sample would be visible in sha_block.
    task automatic do_start(input logic [255:0] d);
        data_in = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        data_in = ~d;
    endtask

    // Ticks until digest_valid is seen; n counts edges since the caller's
    // reference point offset by n0, or -1 if the bound expires.
    task automatic wait_dv(input int n0, output int n);
        n = -1;
        for (int i = n0 + 1; i <= n0 + 60; i++) begin
            tick();
            if (digest_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic logic [511:0] exp_block(input logic [255:0] d);
        return {d, 8'h80, 184'h0, 64'h100};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (sha_init_v() !== 1'b0) begin failures++; $display("FAIL reset_sha_init got=%b exp=0", sha_init_v()); end
        checks++; if (bus.sha_block !== 512'h0) begin failures++; $display("FAIL reset_sha_block got=%h exp=0", bus.sha_block); end
        checks++; if (digest !== 256'h0) begin failures++; $display("FAIL reset_digest got=%h exp=0", digest); end
        checks++; if ({digest_valid, busy, overrun, timeout_err} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {digest_valid, busy, overrun, timeout_err}); end
        checks++; if ({bus.sha_next, bus.sha_mode} !== 2'b01) begin failures++; $display("FAIL const_next_mode got=%b exp=01", {bus.sha_next, bus.sha_mode}); end
    endtask

    function automatic logic sha_init_v();
        return bus.sha_init;
    endfunction

    task automatic test_block_format();
        int i0, d0, n;
        i0 = init_cnt; d0 = dv_cnt;
        core_value = DIG_Z;
        do_start(256'h0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fmt_busy_e0 got=%b exp=1", busy); end
        checks++; if (bus.sha_block !== {256'h0, 8'h80, 184'h0, 64'h100}) begin failures++; $display("FAIL fmt_block got=%h exp=%h", bus.sha_block, {256'h0, 8'h80, 184'h0, 64'h100}); end
        checks++; if (bus.sha_init !== 1'b0) begin failures++; $display("FAIL fmt_init_e0 got=%b exp=0", bus.sha_init); end
        tick();
        checks++; if (bus.sha_init !== 1'b1) begin failures++; $display("FAIL fmt_init_e1 got=%b exp=1", bus.sha_init); end
        tick();
        checks++; if (bus.sha_init !== 1'b0) begin failures++; $display("FAIL fmt_init_e2 got=%b exp=0", bus.sha_init); end
        wait_dv(2, n);
        checks++; if (n !== 14) begin failures++; $display("FAIL fmt_latency got=%0d exp=14", n); end
        checks++; if (digest !== DIG_Z) begin failures++; $display("FAIL fmt_digest got=%h exp=%h", digest, DIG_Z); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fmt_busy_done got=%b exp=0", busy); end
        repeat (5) tick();
        checks++; if (init_cnt - i0 !== 1) begin failures++; $display("FAIL fmt_init_count got=%0d exp=1", init_cnt - i0); end
        checks++; if (dv_cnt - d0 !== 1) begin failures++; $display("FAIL fmt_dv_count got=%0d exp=1", dv_cnt - d0); end
    endtask

    task automatic test_stale_digest();
        int n;
        core_cmd = 2;
        tick();
        core_cmd = 0;
        saw_stale = 1'b0;
        core_value = DIG_A;
        do_start(DAT_A);
        checks++; if (bus.sha_block !== exp_block(DAT_A)) begin failures++; $display("FAIL stale_block got=%h exp=%h", bus.sha_block, exp_block(DAT_A)); end
        wait_dv(0, n);
        checks++; if (n !== 14) begin failures++; $display("FAIL stale_latency got=%0d exp=14", n); end
        checks++; if (digest !== DIG_A) begin failures++; $display("FAIL stale_digest got=%h exp=%h", digest, DIG_A); end
        checks++; if (saw_stale !== 1'b0) begin failures++; $display("FAIL stale_captured got=%b exp=0", saw_stale); end
    endtask

    task automatic test_overrun();
        int i0, d0, n;
        do_reset();
        i0 = init_cnt; d0 = dv_cnt;
        core_value = DIG_B;
        do_start(DAT_A);
        repeat (9) tick();
        do_start(DAT_B);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        checks++; if (bus.sha_block !== exp_block(DAT_A)) begin failures++; $display("FAIL ovr_block got=%h exp=%h", bus.sha_block, exp_block(DAT_A)); end
        wait_dv(10, n);
        checks++; if (digest !== DIG_B) begin failures++; $display("FAIL ovr_digest got=%h exp=%h", digest, DIG_B); end
        repeat (10) tick();
        checks++; if (init_cnt - i0 !== 1) begin failures++; $display("FAIL ovr_init_count got=%0d exp=1", init_cnt - i0); end
        checks++; if (dv_cnt - d0 !== 1) begin failures++; $display("FAIL ovr_dv_count got=%0d exp=1", dv_cnt - d0); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
        checks++; if (bus.sha_block !== exp_block(DAT_A)) begin failures++; $display("FAIL ovr_block_end got=%h exp=%h", bus.sha_block, exp_block(DAT_A)); end
        do_reset();
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_cleared got=%b exp=0", overrun); end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        core_value = DIG_A;
        do_start(DAT_A);
        repeat (13) tick();
        // This start is sampled on the edge where WAIT_DIG completes.
        data_in = DAT_B;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({digest_valid, busy, overrun} !== 3'b101) begin failures++; $display("FAIL b2b_edge dv_busy_ovr got=%b exp=101", {digest_valid, busy, overrun}); end
        checks++; if (bus.sha_block !== exp_block(DAT_A)) begin failures++; $display("FAIL b2b_block_kept got=%h exp=%h", bus.sha_block, exp_block(DAT_A)); end
        core_value = DIG_B;
        do_start(DAT_B);
        checks++; if (busy !== 1'b1 || bus.sha_block !== exp_block(DAT_B)) begin failures++; $display("FAIL b2b_restart busy=%b block=%h exp busy=1 block=%h", busy, bus.sha_block, exp_block(DAT_B)); end
        wait_dv(0, n);
        checks++; if (n !== 14 || digest !== DIG_B) begin failures++; $display("FAIL b2b_second n=%0d digest=%h exp n=14 digest=%h", n, digest, DIG_B); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        core_value = DIG_A;
        do_start(DAT_A);
        wait_dv(0, n);
        checks++; if (digest !== DIG_A) begin failures++; $display("FAIL to_pre_digest got=%h exp=%h", digest, DIG_A); end
        tick();
        core_never = 1'b1;
        do_start(DAT_B);
        repeat (17) tick();
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL to_e17 err=%b busy=%b exp err=0 busy=1", timeout_err, busy); end
        tick();
        checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL to_e18 err=%b busy=%b exp err=1 busy=0", timeout_err, busy); end
        checks++; if (digest !== DIG_A || digest_valid !== 1'b0) begin failures++; $display("FAIL to_digest_kept got=%h dv=%b exp=%h dv=0", digest, digest_valid, DIG_A); end
        tick();
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_pulse_width got=%b exp=0", timeout_err); end
        core_never = 1'b0;
        core_cmd = 1;
        tick();
        core_cmd = 0;
        core_value = DIG_B;
        do_start(DAT_B);
        wait_dv(0, n);
        checks++; if (n !== 14 || digest !== DIG_B) begin failures++; $display("FAIL to_recover n=%0d digest=%h exp n=14 digest=%h", n, digest, DIG_B); end
    endtask

    task automatic test_reset_midrun();
        int d0;
        tick();
        core_value = DIG_A;
        do_start(DAT_A);
        repeat (6) tick();
        d0 = dv_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.sha_init !== 1'b0 || bus.sha_block !== 512'h0) begin failures++; $display("FAIL rst_mid_bus init=%b block=%h exp init=0 block=0", bus.sha_init, bus.sha_block); end
        checks++; if (digest !== 256'h0 || {digest_valid, busy, overrun, timeout_err} !== 4'b0000) begin failures++; $display("FAIL rst_mid_out digest=%h flags=%b exp digest=0 flags=0000", digest, {digest_valid, busy, overrun, timeout_err}); end
        repeat (20) tick();
        checks++; if (dv_cnt - d0 !== 0) begin failures++; $display("FAIL rst_mid_no_dv got=%0d exp=0", dv_cnt - d0); end
        checks++; if (busy !== 1'b0 || digest !== 256'h0) begin failures++; $display("FAIL rst_mid_idle busy=%b digest=%h exp busy=0 digest=0", busy, digest); end
    endtask

    initial begin
        test_reset();
        test_block_format();
        test_stale_digest();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
